// File: rtl/regbank_pkg.sv
// Shared types and defaults for the configuration register bank arbiter.
// FSM encoding, default bank geometry and response error codes.
package regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam int DEF_REG_COUNT = 16;
   localparam int DEF_LOCK_ADDR = 15;

   localparam logic ERR_OK    = 1'b0;
   localparam logic ERR_FAULT = 1'b1;

endpackage

// File: rtl/regbank_arbiter_rr.sv
// Two-requester round-robin grant logic, purely combinational.
// On contention the requester that was not granted last wins.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/regbank_arbiter.sv
// Two-port serialising arbiter for the shared configuration register bank.
// Optional port-1 write lock is enabled with `define REGBANK_WRITE_LOCK_EN.
module regbank_arbiter
   import regbank_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int REG_COUNT  = DEF_REG_COUNT,
   parameter int LOCK_ADDR  = DEF_LOCK_ADDR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_write,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_rsp_valid,
   input  logic                  p0_rsp_ready,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
   output logic                  p0_rsp_err,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_write,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_rsp_valid,
   input  logic                  p1_rsp_ready,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
   output logic                  p1_rsp_err,
   output logic [DATA_WIDTH-1:0] ctrl_word,
   output logic                  busy
);

   localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [31:0] REG_LIM = REG_COUNT;

   state_e                state_q;
   logic                  last_grant_q;
   logic                  port_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic [1:0]            rsp_vld_q;
   logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];

   logic [1:0]            gnt;
   logic                  in_range;
   logic                  locked;
   logic                  wr_reject;
   logic                  rsp_ack;
   logic [IW-1:0]         idx;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   rr_arbiter2 u_arb (
      .req_i        ({p1_req_valid, p0_req_valid}),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt)
   );

   assign p0_req_ready = (state_q == ST_IDLE) & gnt[0];
   assign p1_req_ready = (state_q == ST_IDLE) & gnt[1];

   assign sel_write = gnt[1] ? p1_req_write : p0_req_write;
   assign sel_addr  = gnt[1] ? p1_req_addr  : p0_req_addr;
   assign sel_wdata = gnt[1] ? p1_req_wdata : p0_req_wdata;

   // Compare at full width so out-of-range addresses never alias.
   assign in_range = (32'(addr_q) < REG_LIM);
   assign idx      = addr_q[IW-1:0];

`ifdef REGBANK_WRITE_LOCK_EN
   localparam logic [IW-1:0] LOCK_IDX = IW'(LOCK_ADDR);
   assign locked = mem_q[LOCK_IDX][0];
`else
   logic unused_lock;
   assign unused_lock = (LOCK_ADDR == 0);
   assign locked      = 1'b0;
`endif

   // Only the DSP port is subject to the lock; the I2C host can always clear it.
   assign wr_reject = write_q & port_q & locked;
   assign rsp_ack   = port_q ? p1_rsp_ready : p0_rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= ERR_OK;
         rsp_vld_q    <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|gnt) begin
                  port_q       <= gnt[1];
                  last_grant_q <= gnt[1];
                  write_q      <= sel_write;
                  addr_q       <= sel_addr;
                  wdata_q      <= sel_wdata;
                  state_q      <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               state_q   <= ST_RESP;
               rsp_vld_q <= port_q ? 2'b10 : 2'b01;
               if (!in_range || wr_reject) begin
                  err_q   <= ERR_FAULT;
                  rdata_q <= '0;
               end else if (write_q) begin
                  mem_q[idx] <= wdata_q;
                  err_q      <= ERR_OK;
                  rdata_q    <= '0;
               end else begin
                  err_q   <= ERR_OK;
                  rdata_q <= mem_q[idx];
               end
            end
            ST_RESP: begin
               if (rsp_ack) begin
                  state_q   <= ST_IDLE;
                  rsp_vld_q <= '0;
                  rdata_q   <= '0;
                  err_q     <= ERR_OK;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign p0_rsp_valid = rsp_vld_q[0];
   assign p1_rsp_valid = rsp_vld_q[1];
   assign p0_rsp_rdata = rsp_vld_q[0] ? rdata_q : '0;
   assign p1_rsp_rdata = rsp_vld_q[1] ? rdata_q : '0;
   assign p0_rsp_err   = rsp_vld_q[0] & err_q;
   assign p1_rsp_err   = rsp_vld_q[1] & err_q;

   assign ctrl_word = mem_q[0];
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter: access, arbitration, range, stall,
// write lock (when REGBANK_WRITE_LOCK_EN is defined) and async reset.
module tb_regbank_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       p0_req_valid, p0_req_ready, p0_req_write;
   logic [7:0] p0_req_addr, p0_req_wdata;
   logic       p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
   logic [7:0] p0_rsp_rdata;
   logic       p1_req_valid, p1_req_ready, p1_req_write;
   logic [7:0] p1_req_addr, p1_req_wdata;
   logic       p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
   logic [7:0] p1_rsp_rdata;
   logic [7:0] ctrl_word;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regbank_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .p0_req_valid (p0_req_valid),
      .p0_req_ready (p0_req_ready),
      .p0_req_write (p0_req_write),
      .p0_req_addr  (p0_req_addr),
      .p0_req_wdata (p0_req_wdata),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_ready (p0_rsp_ready),
      .p0_rsp_rdata (p0_rsp_rdata),
      .p0_rsp_err   (p0_rsp_err),
      .p1_req_valid (p1_req_valid),
      .p1_req_ready (p1_req_ready),
      .p1_req_write (p1_req_write),
      .p1_req_addr  (p1_req_addr),
      .p1_req_wdata (p1_req_wdata),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_ready (p1_rsp_ready),
      .p1_rsp_rdata (p1_rsp_rdata),
      .p1_rsp_err   (p1_rsp_err),
      .ctrl_word    (ctrl_word),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int p, input logic v, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
      if (p == 0) begin
         p0_req_valid = v; p0_req_write = w;
         p0_req_addr  = a; p0_req_wdata = d;
      end else begin
         p1_req_valid = v; p1_req_write = w;
         p1_req_addr  = a; p1_req_wdata = d;
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Present a request, check it is accepted at the next edge, drop valid.
   task automatic start(input int p, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input string tag);
      set_req(p, 1'b1, w, a, d);
      #1;
      check({tag, " ready"}, (p == 0) ? p0_req_ready : p1_req_ready, 1);
      step();
      set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
      check({tag, " busy"}, busy, 1);
      check({tag, " early rsp"}, (p == 0) ? p0_rsp_valid : p1_rsp_valid, 0);
   endtask

   task automatic chk_rsp(input int p, input logic [7:0] rd, input logic er,
                          input string tag);
      if (p == 0) begin
         check({tag, " valid"}, p0_rsp_valid, 1);
         check({tag, " rdata"}, p0_rsp_rdata, rd);
         check({tag, " err"}, p0_rsp_err, er);
         check({tag, " other valid"}, p1_rsp_valid, 0);
      end else begin
         check({tag, " valid"}, p1_rsp_valid, 1);
         check({tag, " rdata"}, p1_rsp_rdata, rd);
         check({tag, " err"}, p1_rsp_err, er);
         check({tag, " other valid"}, p0_rsp_valid, 0);
      end
   endtask

   task automatic xact(input int p, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] rd,
                       input logic er, input string tag);
      start(p, w, a, d, tag);
      step();
      chk_rsp(p, rd, er, tag);
      step();
      check({tag, " idle"}, busy, 0);
   endtask

   initial begin
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
      p0_rsp_ready = 1'b1;
      p1_rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst p0 ready", p0_req_ready, 0);
      check("rst p1 ready", p1_req_ready, 0);
      check("rst p0 rsp_valid", p0_rsp_valid, 0);
      check("rst p1 rsp_valid", p1_rsp_valid, 0);
      check("rst p0 rdata", p0_rsp_rdata, 0);
      check("rst p0 err", p0_rsp_err, 0);
      check("rst ctrl", ctrl_word, 0);
      check("rst busy", busy, 0);
      rst = 1'b0;
      step();

      xact(0, 1'b1, 8'd3, 8'h5A, 8'h00, 1'b0, "wr3");
      xact(0, 1'b0, 8'd3, 8'h00, 8'h5A, 1'b0, "rd3");
      xact(1, 1'b1, 8'd5, 8'h11, 8'h00, 1'b0, "p1 wr5");

      // Last grant is now port 1: contention should go 0,1,0.
      set_req(0, 1'b1, 1'b0, 8'd3, 8'h00);
      set_req(1, 1'b1, 1'b0, 8'd5, 8'h00);
      for (int k = 0; k < 3; k++) begin
         automatic int w = k % 2;
         #1;
         check("rr ready0", p0_req_ready, (w == 0));
         check("rr ready1", p1_req_ready, (w == 1));
         step();
         step();
         chk_rsp(w, (w == 0) ? 8'h5A : 8'h11, 1'b0, "rr");
         step();
      end
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

      xact(1, 1'b0, 8'd16, 8'h00, 8'h00, 1'b1, "oor16");
      xact(1, 1'b1, 8'd200, 8'hEE, 8'h00, 1'b1, "oor wr200");
      xact(0, 1'b0, 8'd3, 8'h00, 8'h5A, 1'b0, "rd3 after oor");
      xact(1, 1'b0, 8'd5, 8'h00, 8'h11, 1'b0, "rd5 after oor");

      start(0, 1'b1, 8'd0, 8'hC3, "wrc3");
      check("ctrl in access", ctrl_word, 8'h00);
      step();
      check("ctrl after access", ctrl_word, 8'hC3);
      chk_rsp(0, 8'h00, 1'b0, "wrc3");
      step();

      p0_rsp_ready = 1'b0;
      start(0, 1'b0, 8'd0, 8'h00, "stall");
      step();
      set_req(1, 1'b1, 1'b0, 8'd5, 8'h00);
      for (int i = 0; i < 5; i++) begin
         chk_rsp(0, 8'hC3, 1'b0, "stall");
         check("stall p1 blocked", p1_req_ready, 0);
         step();
      end
      p0_rsp_ready = 1'b1;
      #1;
      check("stall release valid", p0_rsp_valid, 1);
      step();
      xact(1, 1'b0, 8'd5, 8'h00, 8'h11, 1'b0, "p1 after stall");

`ifdef REGBANK_WRITE_LOCK_EN
      xact(0, 1'b1, 8'd15, 8'h01, 8'h00, 1'b0, "lock set");
      xact(1, 1'b1, 8'd2, 8'h77, 8'h00, 1'b1, "locked wr2");
      xact(1, 1'b0, 8'd2, 8'h00, 8'h00, 1'b0, "rd2 locked");
      xact(0, 1'b1, 8'd15, 8'h00, 8'h00, 1'b0, "lock clr");
      xact(1, 1'b1, 8'd2, 8'h77, 8'h00, 1'b0, "unlocked wr2");
      xact(1, 1'b0, 8'd2, 8'h00, 8'h77, 1'b0, "rd2 unlocked");
`else
      xact(0, 1'b1, 8'd15, 8'h01, 8'h00, 1'b0, "reg15 wr");
      xact(1, 1'b1, 8'd2, 8'h77, 8'h00, 1'b0, "nolock wr2");
      xact(1, 1'b0, 8'd2, 8'h00, 8'h77, 1'b0, "nolock rd2");
`endif

      p0_rsp_ready = 1'b0;
      start(0, 1'b0, 8'd3, 8'h00, "pre-rst");
      step();
      chk_rsp(0, 8'h5A, 1'b0, "pre-rst");
      rst = 1'b1;
      #1;
      check("midrst p0 valid", p0_rsp_valid, 0);
      check("midrst p0 rdata", p0_rsp_rdata, 0);
      check("midrst p0 err", p0_rsp_err, 0);
      check("midrst ctrl", ctrl_word, 0);
      check("midrst busy", busy, 0);
      step();
      rst = 1'b0;
      p0_rsp_ready = 1'b1;
      step();
      xact(0, 1'b0, 8'd3, 8'h00, 8'h00, 1'b0, "rd3 post-rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-port arbiter that owns the shared configuration register bank and serialises accesses to it. Port 0 carries the I2C slave bridge's AXI-lite read/write traffic. Port 1 carries the Doppler DSP control path. Requests are granted round-robin, one outstanding transaction at a time, with range checking and an optional write lock. Register 0 is exported continuously as the control word for downstream logic and LEDs.

## Interface
Parameters:
- ADDR_WIDTH, 8, request address width
- DATA_WIDTH, 8, register and data width
- REG_COUNT, 16, number of implemented registers; legal addresses are 0..REG_COUNT-1
- LOCK_ADDR, 15, address of the lock register (used only with the lock feature)

Ports (n = 0, 1, one identical set per requester):
- clk  in  1  single clock; all logic runs on the rising edge
- rst  in  1  reset, asynchronous, active-high
- pn_req_valid  in  1  request valid
- pn_req_ready  out  1  request accepted in this cycle
- pn_req_write  in  1  1 = write, 0 = read
- pn_req_addr  in  ADDR_WIDTH  register address
- pn_req_wdata  in  DATA_WIDTH  write data
- pn_rsp_valid  out  1  response valid
- pn_rsp_ready  in  1  response consumed
- pn_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- pn_rsp_err  out  1  out-of-range address, or write rejected by the lock
- ctrl_word  out  DATA_WIDTH  live contents of register 0
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** when any pn_req_valid is high, grant one port.
  - pn_req_ready is combinational: high only in IDLE and only for the granted port.
  - On the handshake, latch the port id, write flag, address and wdata, then go to ACCESS.
- **Arbitration:** round-robin on a last_grant register.
  - When both ports are valid, grant the port that is not last_grant.
  - last_grant resets to 1, so port 0 wins the first contention.
  - With a single valid port, that port is always granted.
- **ACCESS:** exactly one cycle; the bank is touched only here.
  - Range check: addr >= REG_COUNT gives err=1 and rdata=0; no write is performed.
  - Legal write: mem[addr] <= wdata; rdata=0; err=0.
  - Legal read: rdata = mem[addr]; err=0.
  - Always go to RESP.
- **RESP:** assert rsp_valid, rdata and err on the latched port only.
  - Hold all three stable until that port's rsp_ready is high.
  - On the rsp_ready handshake, return to IDLE.
  - The other port's rsp_valid stays 0.
- No pipelining: a port may present its next request while its own response is pending; that request waits until the FSM is back in IDLE.
- A request is never accepted while the FSM is outside IDLE.
- ctrl_word follows mem[0] and updates in the cycle after the ACCESS write.

## Timing
- Reset values: every register 0; FSM in IDLE; last_grant=1.
  - Outputs: pn_req_ready=0 (no valid requests), pn_rsp_valid=0, pn_rsp_rdata=0, pn_rsp_err=0, ctrl_word=0, busy=0.
- Latency: handshake at edge E0; ACCESS during the following cycle; rsp_valid high after edge E1.
  - A response is therefore visible 1 cycle after the accept cycle.
- Minimum turnaround is 3 cycles per transaction (IDLE, ACCESS, RESP with rsp_ready already high).
- Simultaneous requests: the non-last_grant port wins. The loser's valid must stay high, and it is granted at the next IDLE, so it waits at most one transaction.
- Reset mid-operation: asynchronous return to IDLE; any pending response is dropped without completing; the bank is cleared.
- Address wrap-around is not supported: out-of-range addresses error and do not alias.

## Configuration
- Macro: REGBANK_WRITE_LOCK_EN.
- Defined:
  - Bit 0 of mem[LOCK_ADDR] is the lock bit.
  - While it is 1, port 1 writes to any address are rejected: err=1 and no write.
  - Port 0 (the I2C host) can always write, including clearing the lock.
  - Reads are unaffected.
- Undefined:
  - LOCK_ADDR is an ordinary register and no write is rejected.
  - The lock logic is not synthesised.

## Structure
- Shared package regbank_pkg holds:
  - FSM state encoding (IDLE/ACCESS/RESP)
  - default REG_COUNT and LOCK_ADDR
  - err code constants
- One sub-module, rr_arbiter2: two requests and last_grant in, one-hot grant out, purely combinational.
- Storage is a flat register array with asynchronous reset; no RAM inference.

## Test plan
- Reset, then port 0 writes 0x5A to addr 3, then port 0 reads addr 3 -> write response err=0, rdata=0; read response rdata=0x5A, err=0; rsp_valid first high 1 cycle after the accept cycle.
- Both ports assert a read in the same cycle, three times in a row -> grant order 0,1,0; each response appears only on its own port.
- Port 1 reads addr 16 with REG_COUNT=16 -> err=1, rdata=0x00, bank unchanged.
- Port 0 writes 0xC3 to addr 0 -> ctrl_word becomes 0xC3 in the cycle after ACCESS; a read response with rsp_ready held low for 5 cycles stays stable and blocks port 1.
- With REGBANK_WRITE_LOCK_EN defined: port 0 writes 0x01 to addr 15; port 1 writes 0x77 to addr 2 -> err=1, addr 2 still 0x00; port 0 writes 0x00 to addr 15, port 1 repeats the write -> success.
- Assert rst while in RESP with rsp_ready low -> all outputs 0 immediately, busy=0, a read of addr 3 after reset returns 0x00.
